// File: rtl/decode_stage_pkg.sv
// Shared decode types, control-vector constants and immediate extractors for the ID stage.
// Immediates are built at full 64-bit width; 32-bit datapaths keep the low half.
package decode_stage_pkg;

    typedef enum logic [4:0] {
        OPC_LOAD   = 5'h00,
        OPC_OPIMM  = 5'h04,
        OPC_AUIPC  = 5'h05,
        OPC_STORE  = 5'h08,
        OPC_OP     = 5'h0C,
        OPC_LUI    = 5'h0D,
        OPC_BRANCH = 5'h18,
        OPC_JALR   = 5'h19,
        OPC_JAL    = 5'h1B
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_codes_t;

    typedef enum logic [1:0] {
        NON_TYPE         = 2'd0,
        JAL_TYPE         = 2'd1,
        JALR_TYPE        = 2'd2,
        CONDITIONAL_TYPE = 2'd3
    } branch_type_t;

    localparam logic [9:0] CTRL_LUI    = 10'h040;
    localparam logic [9:0] CTRL_AUIPC  = 10'h05E;
    localparam logic [9:0] CTRL_OPIMM  = 10'h04E;
    localparam logic [9:0] CTRL_OP     = 10'h046;
    localparam logic [9:0] CTRL_LOAD   = 10'h06F;
    localparam logic [9:0] CTRL_STORE  = 10'h08E;
    localparam logic [9:0] CTRL_JAL    = 10'h042;
    localparam logic [9:0] CTRL_JALR   = 10'h04A;
    localparam logic [9:0] CTRL_BRANCH = 10'h000;

    typedef struct packed {
        logic [63:0]  pc;
        logic [63:0]  imm;
        logic [9:0]   ctrl;
        alu_codes_t   alu;
        branch_type_t branch_type;
        logic [2:0]   funct3;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         illegal;
    } decoded_t;

    function automatic logic [63:0] imm_i(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [63:0] imm_s(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [63:0] imm_u(input logic [31:0] instr);
        return {{32{instr[31]}}, instr[31:12], 12'b0};
    endfunction

    function automatic logic [63:0] imm_j(input logic [31:0] instr);
        return {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational RV32I/RV64I base decoder: raw instruction + pc to a decoded_t bundle.
module instr_decoder
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [63:0] pc,
    output decoded_t    dec
);

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        dec             = '0;
        dec.pc          = pc;
        dec.funct3      = funct3;
        dec.rs1         = instr[19:15];
        dec.rs2         = instr[24:20];
        dec.rd          = instr[11:7];
        dec.alu         = ALU_ADD;
        dec.branch_type = NON_TYPE;
        illegal         = (instr[1:0] != 2'b11);

        case (instr[6:2])
            OPC_LUI:   begin dec.ctrl = CTRL_LUI;   dec.imm = imm_u(instr); end
            OPC_AUIPC: begin dec.ctrl = CTRL_AUIPC; dec.imm = imm_u(instr); end
            OPC_LOAD:  begin dec.ctrl = CTRL_LOAD;  dec.imm = imm_i(instr); end
            OPC_STORE: begin dec.ctrl = CTRL_STORE; dec.imm = imm_s(instr); end
            OPC_OPIMM: begin
                dec.ctrl = CTRL_OPIMM;
                dec.imm  = imm_i(instr);
                // only the shift-right pair uses bit 30 to pick arithmetic vs logical
                dec.alu  = alu_codes_t'({(funct3 == 3'b101) ? instr[30] : 1'b0, funct3});
            end
            OPC_OP: begin
                dec.ctrl = CTRL_OP;
                dec.alu  = alu_codes_t'({instr[30], funct3});
                if (!((funct7 == 7'h00) ||
                      ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
                    illegal = 1'b1;
            end
            OPC_JAL: begin
                dec.ctrl        = CTRL_JAL;
                dec.imm         = imm_j(instr);
                dec.branch_type = JAL_TYPE;
            end
            OPC_JALR: begin
                dec.ctrl        = CTRL_JALR;
                dec.imm         = imm_i(instr);
                dec.branch_type = JALR_TYPE;
            end
            OPC_BRANCH: begin
                dec.ctrl        = CTRL_BRANCH;
                dec.imm         = imm_b(instr);
                dec.branch_type = CONDITIONAL_TYPE;
                case (funct3)
                    3'b000, 3'b001: dec.alu = ALU_SUB;
                    3'b100, 3'b101: dec.alu = ALU_SLT;
                    3'b110, 3'b111: dec.alu = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            dec.ctrl        = '0;
            dec.imm         = '0;
            dec.alu         = ALU_ADD;
            dec.branch_type = NON_TYPE;
        end
        dec.illegal = illegal;
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: instr_decoder feeding an OUT register backed by a one-deep skid register.
// state | meaning
// EMPTY | nothing held, ready to accept
// ONE   | OUT valid, skid empty, ready to accept
// FULL  | OUT and skid valid, not ready
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [9:0]      ex_ctrl_o,
    output logic [3:0]      ex_alu_op_o,
    output logic [1:0]      ex_branch_type_o,
    output logic [2:0]      ex_funct3_o,
    output logic [4:0]      ex_rs1_o,
    output logic [4:0]      ex_rs2_o,
    output logic [4:0]      ex_rd_o,
    output logic            ex_illegal_o
);

    // bit 0 = OUT valid, bit 1 = skid valid, so handshake outputs come straight off flops
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } occ_t;

    occ_t        state;
    decoded_t    dec, out_q, skid_q;
    logic [63:0] pc_ext;
    logic        load;

    assign pc_ext = 64'(if_pc_i);

    instr_decoder u_instr_decoder (
        .instr (if_instr_i),
        .pc    (pc_ext),
        .dec   (dec)
    );

    assign if_ready_o = ~state[1];
    assign ex_valid_o = state[0];
    // a dropped illegal instruction still completes the fetch handshake
    assign load = if_valid_i & if_ready_o & ~flush_i & (ILLEGAL_TRAP | ~dec.illegal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (load) begin
                    out_q <= dec;
                    state <= ONE;
                end
                ONE: begin
                    if (ex_ready_i) begin
                        if (load) out_q <= dec;
                        else      state <= EMPTY;
                    end else if (load) begin
                        skid_q <= dec;
                        state  <= FULL;
                    end
                end
                FULL: if (ex_ready_i) begin
                    out_q <= skid_q;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign ex_pc_o          = out_q.pc[XLEN-1:0];
    assign ex_imm_o         = out_q.imm[XLEN-1:0];
    assign ex_ctrl_o        = out_q.ctrl;
    assign ex_alu_op_o      = out_q.alu;
    assign ex_branch_type_o = out_q.branch_type;
    assign ex_funct3_o      = out_q.funct3;
    assign ex_rs1_o         = out_q.rs1;
    assign ex_rs2_o         = out_q.rs2;
    assign ex_rd_o          = out_q.rd;
    assign ex_illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a 32-bit trapping instance and a 64-bit dropping instance
// share one input stream; a predictor fills per-instance queues and a monitor drains them.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [9:0]  ctrl;
        logic [3:0]  alu;
        logic [1:0]  bt;
        logic [2:0]  f3;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
    } exp_t;

    localparam logic [4:0] OPS [9] = '{5'h0D, 5'h05, 5'h04, 5'h0C, 5'h00, 5'h08, 5'h1B, 5'h19, 5'h18};
    localparam logic [63:0] M32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] M64 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;

    logic        a_ready, a_valid, a_ill, b_ready, b_valid, b_ill;
    logic [31:0] a_pc, a_imm;
    logic [63:0] b_pc, b_imm;
    logic [9:0]  a_ctrl, b_ctrl;
    logic [3:0]  a_alu, b_alu;
    logic [1:0]  a_bt, b_bt;
    logic [2:0]  a_f3, b_f3;
    logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;

    int   n_cmp = 0, n_err = 0;
    exp_t qa[$], qb[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ILLEGAL_TRAP(1'b1)) u_a (
        .clk(clk), .rst(rst), .if_valid_i(valid), .if_ready_o(a_ready), .if_instr_i(instr),
        .if_pc_i(pc[31:0]), .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(a_valid),
        .ex_pc_o(a_pc), .ex_imm_o(a_imm), .ex_ctrl_o(a_ctrl), .ex_alu_op_o(a_alu),
        .ex_branch_type_o(a_bt), .ex_funct3_o(a_f3), .ex_rs1_o(a_rs1), .ex_rs2_o(a_rs2),
        .ex_rd_o(a_rd), .ex_illegal_o(a_ill));

    decode_stage #(.XLEN(64), .ILLEGAL_TRAP(1'b0)) u_b (
        .clk(clk), .rst(rst), .if_valid_i(valid), .if_ready_o(b_ready), .if_instr_i(instr),
        .if_pc_i(pc), .flush_i(flush), .ex_ready_i(ex_ready), .ex_valid_o(b_valid),
        .ex_pc_o(b_pc), .ex_imm_o(b_imm), .ex_ctrl_o(b_ctrl), .ex_alu_op_o(b_alu),
        .ex_branch_type_o(b_bt), .ex_funct3_o(b_f3), .ex_rs1_o(b_rs1), .ex_rs2_o(b_rs2),
        .ex_rd_o(b_rd), .ex_illegal_o(b_ill));

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // reference decoder built from the ISA field layout using integer arithmetic
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p);
        exp_t e;
        int   si;
        si    = ins;
        e.pc  = p; e.imm = 0; e.ctrl = 0; e.alu = 0; e.bt = NON_TYPE; e.ill = 0;
        e.f3  = ins[14:12]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        if (ins[1:0] != 2'b11) e.ill = 1;
        else case (ins[6:2])
            5'h0D: begin e.ctrl = 10'h040; e.imm = longint'(si) - longint'(ins[11:0]); end
            5'h05: begin e.ctrl = 10'h05E; e.imm = longint'(si) - longint'(ins[11:0]); end
            5'h04: begin
                e.ctrl = 10'h04E; e.imm = longint'(si >>> 20);
                e.alu  = {(e.f3 == 3'd5) ? ins[30] : 1'b0, e.f3};
            end
            5'h0C: begin
                e.ctrl = 10'h046; e.alu = {ins[30], e.f3};
                if (!(ins[31:25] == 7'h00 || (ins[31:25] == 7'h20 && (e.f3 == 0 || e.f3 == 5)))) e.ill = 1;
            end
            5'h00: begin e.ctrl = 10'h06F; e.imm = longint'(si >>> 20); end
            5'h08: begin e.ctrl = 10'h08E; e.imm = longint'((si >>> 25) * 32 + int'(ins[11:7])); end
            5'h1B: begin
                e.ctrl = 10'h042; e.bt = JAL_TYPE;
                e.imm  = longint'((si >>> 31) * 1048576 + int'(ins[19:12]) * 4096 +
                                  int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            end
            5'h19: begin e.ctrl = 10'h04A; e.bt = JALR_TYPE; e.imm = longint'(si >>> 20); end
            5'h18: begin
                e.bt  = CONDITIONAL_TYPE;
                e.imm = longint'((si >>> 31) * 4096 + int'(ins[7]) * 2048 +
                                 int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
                if (e.f3 == 2 || e.f3 == 3) e.ill = 1;
                else e.alu = (e.f3 < 2) ? 4'b1000 : (e.f3 < 6) ? 4'b0010 : 4'b0011;
            end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.ctrl = 0; e.alu = 0; e.bt = NON_TYPE; end
        return e;
    endfunction

    task automatic check_item(input string t, input exp_t e, input logic [63:0] m,
                              input logic [63:0] p, input logic [63:0] im, input logic [9:0] c,
                              input logic [3:0] al, input logic [1:0] bt, input logic [2:0] f3,
                              input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                              input logic il);
        cmp({t, "_pc"}, p, e.pc & m);
        if (!e.ill) cmp({t, "_imm"}, im, e.imm & m);
        cmp({t, "_ctrl"}, 64'(c), 64'(e.ctrl));
        cmp({t, "_alu"}, 64'(al), 64'(e.alu));
        cmp({t, "_btype"}, 64'(bt), 64'(e.bt));
        cmp({t, "_funct3"}, 64'(f3), 64'(e.f3));
        cmp({t, "_rs1"}, 64'(r1), 64'(e.rs1));
        cmp({t, "_rs2"}, 64'(r2), 64'(e.rs2));
        cmp({t, "_rd"}, 64'(rd), 64'(e.rd));
        cmp({t, "_illegal"}, 64'(il), 64'(e.ill));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) begin
            r[6:2] = OPS[k];
            r[1:0] = 2'b11;
            if (k == 3 && r[26]) r[31:25] = r[30] ? 7'h20 : 7'h00;
        end
        return r;
    endfunction

    // predictor: what each instance must eventually present
    initial forever begin
        exp_t e;
        @(negedge clk); #3;
        if (!rst && valid && !flush) begin
            e = model(instr, pc);
            if (a_ready) qa.push_back(e);
            if (b_ready && !e.ill) qb.push_back(e);
        end
    end

    // monitor: pop on every ex handshake, and check hold stability under backpressure
    initial begin
        exp_t        e;
        logic        held = 1'b0;
        logic [31:0] hpc = '0, himm = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                qa.delete(); qb.delete(); held = 1'b0;
            end else begin
                if (held) begin
                    cmp("hold_pc", 64'(a_pc), 64'(hpc));
                    cmp("hold_imm", 64'(a_imm), 64'(himm));
                end
                held = a_valid && !ex_ready; hpc = a_pc; himm = a_imm;
                if (a_valid && ex_ready) begin
                    if (qa.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL a_unexpected actual=pc %h required=no output", a_pc);
                    end else begin
                        e = qa.pop_front();
                        check_item("a", e, M32, 64'(a_pc), 64'(a_imm), a_ctrl, a_alu, a_bt,
                                   a_f3, a_rs1, a_rs2, a_rd, a_ill);
                    end
                end
                if (b_valid && ex_ready) begin
                    if (qb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL b_unexpected actual=pc %h required=no output", b_pc);
                    end else begin
                        e = qb.pop_front();
                        check_item("b", e, M64, b_pc, b_imm, b_ctrl, b_alu, b_bt,
                                   b_f3, b_rs1, b_rs2, b_rd, b_ill);
                    end
                end
                if (flush) begin qa.delete(); qb.delete(); held = 1'b0; end
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] i, input logic [63:0] p,
                       input logic f, input logic r);
        @(negedge clk);
        valid = v; instr = i; pc = p; flush = f; ex_ready = r;
    endtask

    initial begin
        #1;
        cmp("rst_a_valid", 64'(a_valid), 0);
        cmp("rst_a_ready", 64'(a_ready), 1);
        cmp("rst_a_pc", 64'(a_pc), 0);
        cmp("rst_a_imm", 64'(a_imm), 0);
        cmp("rst_a_ctrl", 64'(a_ctrl), 0);
        cmp("rst_b_valid", 64'(b_valid), 0);
        cmp("rst_b_ready", 64'(b_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        cyc(1, 32'hFFF10093, 64'h100, 0, 1);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("addi_valid", 64'(a_valid), 1);
        cmp("addi_imm", 64'(a_imm), 64'hFFFF_FFFF);
        cmp("addi_ctrl", 64'(a_ctrl), 64'h04E);
        cmp("addi_alu", 64'(a_alu), 0);
        cmp("addi_rs1", 64'(a_rs1), 2);
        cmp("addi_rd", 64'(a_rd), 1);
        cmp("addi_pc", 64'(a_pc), 64'h100);

        cyc(1, 32'hFE000EE3, 64'h104, 0, 1);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("beq_imm", 64'(a_imm), 64'hFFFF_FFFC);
        cmp("beq_alu", 64'(a_alu), 64'h8);
        cmp("beq_btype", 64'(a_bt), 64'(CONDITIONAL_TYPE));
        cmp("beq_funct3", 64'(a_f3), 0);

        cyc(1, 32'h800002B7, 64'h108, 0, 1);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("lui64_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
        cmp("lui64_ctrl", 64'(b_ctrl), 64'h040);
        cmp("lui32_imm", 64'(a_imm), 64'h8000_0000);

        cyc(1, 32'h0000_0000, 64'h10C, 0, 1);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("ill_a_valid", 64'(a_valid), 1);
        cmp("ill_a_flag", 64'(a_ill), 1);
        cmp("ill_a_ctrl", 64'(a_ctrl), 0);
        cmp("ill_b_dropped", 64'(b_valid), 0);

        cyc(1, 32'h00100093, 64'h200, 0, 0);
        cyc(1, 32'h00200113, 64'h204, 0, 0);
        cyc(0, 0, 0, 0, 0); #1;
        cmp("bp_a_ready", 64'(a_ready), 0);
        cmp("bp_b_ready", 64'(b_ready), 0);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("bp_first_valid", 64'(a_valid), 1);
        cmp("bp_first_pc", 64'(a_pc), 64'h200);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("bp_second_valid", 64'(a_valid), 1);
        cmp("bp_second_pc", 64'(a_pc), 64'h204);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("bp_drained", 64'(a_valid), 0);

        cyc(1, 32'h00300193, 64'h300, 0, 0);
        cyc(1, 32'h00400213, 64'h304, 0, 0);
        cyc(1, 32'h00500293, 64'h308, 1, 0);
        cyc(0, 0, 0, 0, 1); #1;
        cmp("flush_a_valid", 64'(a_valid), 0);
        cmp("flush_a_ready", 64'(a_ready), 1);
        cmp("flush_b_valid", 64'(b_valid), 0);
        cmp("flush_b_ready", 64'(b_ready), 1);
        repeat (3) cyc(0, 0, 0, 0, 1);

        for (int n = 0; n < 2000; n++)
            cyc(($urandom_range(0, 9) < 7), rand_instr(), {$urandom, $urandom} & ~64'h3,
                ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 6));

        repeat (6) cyc(0, 0, 0, 0, 1);
        #4;
        cmp("drain_qa_empty", 64'(qa.size()), 0);
        cmp("drain_qb_empty", 64'(qb.size()), 0);

        cyc(1, 32'h00600313, 64'h400, 0, 0);
        cyc(1, 32'h00700393, 64'h404, 0, 0);
        cyc(0, 0, 0, 0, 0); #1;
        cmp("prefull_a_valid", 64'(a_valid), 1);
        cmp("prefull_a_ready", 64'(a_ready), 0);
        rst = 1'b1; #1;
        cmp("arst_a_valid", 64'(a_valid), 0);
        cmp("arst_a_ready", 64'(a_ready), 1);
        cmp("arst_a_pc", 64'(a_pc), 0);
        cmp("arst_b_valid", 64'(b_valid), 0);
        cmp("arst_b_ready", 64'(b_ready), 1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Pipelined RV32I/RV64I instruction-decode stage sitting between fetch and execute. It decodes the opcode into control vectors, ALU ops, branch types and XLEN-wide immediates, then registers the result into the ID/EX boundary. The valid/ready handshakes on both sides are fully registered through a 2-entry skid buffer. The stage supports flush and full throughput under backpressure.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN, pc width XLEN
ILLEGAL_TRAP, 1, 1: undecodable instructions propagate with ex_illegal_o=1; 0: they are silently dropped (consumed, never presented)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
if_valid_i  in  1  fetch presents an instruction
if_ready_o  out  1  stage can accept; registered
if_instr_i  in  32  raw instruction
if_pc_i  in  XLEN  instruction pc
flush_i  in  1  kill all held and incoming instructions
ex_ready_i  in  1  execute accepts this cycle
ex_valid_o  out  1  decoded instruction valid
ex_pc_o  out  XLEN  pc of decoded instruction
ex_imm_o  out  XLEN  format-selected, sign-extended immediate
ex_ctrl_o  out  10  per-opcode control vector
ex_alu_op_o  out  4  alu_codes_t
ex_branch_type_o  out  2  branch_type_t
ex_funct3_o  out  3  funct3 (branch condition / load-store size)
ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  register indices
ex_illegal_o  out  1  undecodable instruction

Behaviour:
- Reset (async, immediate): out/skid valid=0; all ex_* outputs=0; if_ready_o=1.
- Latency: 1 cycle from accept (if_valid_i & if_ready_o) to ex_valid_o.
- Storage: OUT register (drives ex_*) plus SKID register. if_ready_o = !skid_valid.
- Occupancy states: EMPTY (out=0, skid=0), ONE (out=1, skid=0), FULL (out=1, skid=1).
- EMPTY: accept goes to ONE with OUT=decode(in).
- ONE: if ex_ready_i, OUT is consumed. An accept in the same cycle replaces OUT (stay ONE); otherwise go to EMPTY.
- ONE: if !ex_ready_i, an accept goes to SKID (FULL); otherwise stay.
- FULL: if ex_ready_i, SKID moves to OUT (ONE); no accept is possible.
- Ordering is strictly in-order, with no loss or duplication.
- ex_* outputs are held stable while ex_valid_o & !ex_ready_i.
- flush_i has highest priority. Next cycle is EMPTY and if_ready_o=1; a same-cycle input is discarded. A same-cycle ex handshake still counts as consumed.
- ctrl per opcode[6:2]: LUI 0x040, AUIPC 0x05E, OPIMM 0x04E, OP 0x046, LOAD 0x06F, STORE 0x08E, JAL 0x042, JALR 0x04A, BRANCH 0x000.
- ALU op:
  - OP: {instr[30], funct3}.
  - OPIMM: {funct3==101 ? instr[30] : 0, funct3}.
  - BRANCH: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU.
  - All others: ADD.
- branch_type: JAL→JAL_TYPE, JALR→JALR_TYPE, BRANCH→CONDITIONAL_TYPE, else NON_TYPE.
- Immediates: I/S/B/U/J formats, sign bit instr[31] extended to XLEN. U-type is {instr[31:12],12'b0}, sign-extended for XLEN=64. R-type immediate is 0.
- Illegal conditions:
  - opcode[1:0] != 11;
  - unknown opcode[6:2];
  - BRANCH funct3 010/011;
  - OP funct7 other than 0x00/0x20 (0x20 only with funct3 000/101).
- Illegal instructions produce ctrl=0, alu=ADD, branch_type=NON_TYPE, ex_illegal_o=1. With ILLEGAL_TRAP=0 the handshake completes but nothing is loaded.

Decomposition:
- coreUtils gains:
  - parametric imm functions (XLEN-width return);
  - ctrl-vector localparams;
  - decoded_t packed struct (pc, imm, ctrl, alu, branch_type, funct3, rs1, rs2, rd, illegal).
- Sub-module instr_decoder: purely combinational, instr+pc → decoded_t. decode_stage owns only the skid/OUT registers and handshake.

Test Plan:
- addi x1,x2,-1: 0xFFF10093, pc 0x100, ex_ready=1 → next cycle ex_valid=1, imm=0xFFFFFFFF, ctrl=0x04E, alu=0000, rs1=2, rd=1, pc=0x100.
- beq x0,x0,-4: 0xFE000EE3 → imm=0xFFFFFFFC, alu=SUB(1000), branch_type=CONDITIONAL_TYPE, funct3=000.
- Backpressure, ex_ready=0: accept A then B → if_ready_o=0 the cycle after B. Raise ex_ready → A then B on consecutive cycles, none lost or duplicated.
- FULL state + flush_i with if_valid_i=1 → next cycle ex_valid=0, if_ready_o=1; flushed/incoming instructions never appear.
- XLEN=64, lui x5,0x80000: 0x800002B7 → imm=0xFFFFFFFF80000000, ctrl=0x040.
- 0x00000000 (ILLEGAL_TRAP=1) → ex_illegal_o=1, ctrl=0. Then assert rst mid-FULL → ex_valid_o=0 same cycle (async), if_ready_o=1.
